// File: rtl/isa_prefetch_cache_pkg.sv
// Shared parameters and FSM encoding for the instruction window cache.
// Window geometry, bus widths and the fill-state machine encoding live here.
// Imported by the interface, the window RAM and the top.
package isa_prefetch_cache_pkg;
   localparam int ISA_WIDTH      = 30;
   localparam int ISA_DEPTH      = 72;
   localparam int ADDR_WIDTH_MEM = 16;
   localparam int DDR_ADDR_WIDTH = 28;
   localparam int LEN_WIDTH      = 10;
   localparam int RAM_AW         = $clog2(ISA_DEPTH);
   localparam int CNT_WIDTH      = $clog2(ISA_DEPTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL, ST_RESP} state_t;

   // Offset of a PC into the window; the extra top bit flags a borrow (pc below base).
   function automatic logic [ADDR_WIDTH_MEM:0] window_off(input logic [ADDR_WIDTH_MEM-1:0] pc,
                                                          input logic [ADDR_WIDTH_MEM-1:0] base);
      return {1'b0, pc} - {1'b0, base};
   endfunction
endpackage

// File: rtl/isa_prefetch_cache_if.sv
// Fetch-port and DDR burst-read signals of the instruction window cache.
// slave modport is the cache side, master modport is the core/DDR side.
// All signals are in the single DDR UI clock domain.
interface isa_prefetch_cache_if;
   import isa_prefetch_cache_pkg::*;

   logic                      fetch_req;
   logic [ADDR_WIDTH_MEM-1:0] pc_addr;
   logic                      flush;
   logic [ISA_WIDTH-1:0]      instruction;
   logic                      instr_valid;
   logic                      stall;
   logic                      ISA_read_req;
   logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
   logic [LEN_WIDTH-1:0]      isa_read_len;
   logic                      ddr_rdy;
   logic                      rd_burst_data_valid;
   logic [LEN_WIDTH-1:0]      rd_cnt_isa;
   logic [ISA_WIDTH-1:0]      instruction_to_cache;

   modport slave (
      input  fetch_req, pc_addr, flush, ddr_rdy, rd_burst_data_valid, rd_cnt_isa, instruction_to_cache,
      output instruction, instr_valid, stall, ISA_read_req, ISA_read_addr, isa_read_len
   );

   modport master (
      output fetch_req, pc_addr, flush, ddr_rdy, rd_burst_data_valid, rd_cnt_isa, instruction_to_cache,
      input  instruction, instr_valid, stall, ISA_read_req, ISA_read_addr, isa_read_len
   );
endinterface

// File: rtl/isa_prefetch_cache_window_ram.sv
// Instruction window storage: ISA_DEPTH x ISA_WIDTH simple dual-port RAM.
// Synchronous write, synchronous read with 1-cycle latency.
// Read data holds its value when no read is issued; only the read register is reset.
module isa_window_ram
   import isa_prefetch_cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [RAM_AW-1:0]    wr_addr,
   input  logic [ISA_WIDTH-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [RAM_AW-1:0]    rd_addr,
   output logic [ISA_WIDTH-1:0] rd_data
);
   logic [ISA_WIDTH-1:0] mem [ISA_DEPTH];

   // Write port; storage itself is not reset, validity is tracked by the owner.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port doubling as the held instruction output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/isa_prefetch_cache.sv
// Instruction window cache between core fetch port and DDR burst-read interface.
// Hit: instruction 1 cycle after fetch; miss: one ISA_DEPTH-beat burst, then reply.
// stall is raised for the whole miss; the burst request waits for ddr_rdy.
module isa_prefetch_cache
   import isa_prefetch_cache_pkg::*;
#(
   parameter logic [DDR_ADDR_WIDTH-1:0] ISA_DDR_BASE = '0,
   parameter int                        ADDR_SHIFT   = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   isa_prefetch_cache_if.slave bus
);
   state_t                    state, state_n;
   logic                      valid;
   logic [ADDR_WIDTH_MEM-1:0] base;
   logic [CNT_WIDTH-1:0]      cnt;
   logic                      flush_pend;
   logic                      stall_r;
   logic                      read_req;
   logic [DDR_ADDR_WIDTH-1:0] read_addr;
   logic                      instr_valid_r;
   logic [ADDR_WIDTH_MEM:0]   off;
   logic                      hit, beat_ok, last_beat, fill_flush;
   logic                      miss, hit_rd, resp_rd;

   assign off        = window_off(bus.pc_addr, base);
   assign hit        = valid && !off[ADDR_WIDTH_MEM] && (off < (ADDR_WIDTH_MEM+1)'(ISA_DEPTH));
   // Only in-range beats received while a burst is outstanding are stored and counted.
   assign beat_ok    = bus.rd_burst_data_valid && (bus.rd_cnt_isa < LEN_WIDTH'(ISA_DEPTH))
                       && (state == ST_REQ || state == ST_FILL);
   assign last_beat  = beat_ok && (state == ST_FILL) && (cnt == CNT_WIDTH'(ISA_DEPTH - 1));
   // A flush arriving together with the final beat still discards the fill.
   assign fill_flush = flush_pend || bus.flush;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_n = state;
      miss    = 1'b0;
      hit_rd  = 1'b0;
      resp_rd = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.fetch_req && (bus.flush || !hit)) begin
               miss    = 1'b1;
               state_n = ST_REQ;
            end else if (bus.fetch_req) begin
               hit_rd = 1'b1;
            end
         end
         ST_REQ:  if (bus.rd_burst_data_valid) state_n = ST_FILL;
         ST_FILL: if (last_beat) state_n = fill_flush ? ST_IDLE : ST_RESP;
         ST_RESP: begin
            resp_rd = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Window bookkeeping, burst request and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid         <= 1'b0;
         base          <= '0;
         cnt           <= '0;
         flush_pend    <= 1'b0;
         stall_r       <= 1'b0;
         read_req      <= 1'b0;
         read_addr     <= '0;
         instr_valid_r <= 1'b0;
      end else begin
         instr_valid_r <= hit_rd || resp_rd;
         if (miss) begin
            base       <= bus.pc_addr;
            valid      <= 1'b0;
            stall_r    <= 1'b1;
            cnt        <= '0;
            flush_pend <= 1'b0;
            read_addr  <= ISA_DDR_BASE + (DDR_ADDR_WIDTH'(bus.pc_addr) << ADDR_SHIFT);
         end else if (state == ST_IDLE && bus.flush) begin
            valid <= 1'b0;
         end
         if (state == ST_REQ) begin
            if (bus.rd_burst_data_valid) read_req <= 1'b0;
            else if (bus.ddr_rdy)        read_req <= 1'b1;
         end
         if (beat_ok) cnt <= cnt + CNT_WIDTH'(1);
         if ((state == ST_REQ || state == ST_FILL) && bus.flush) flush_pend <= 1'b1;
         if (last_beat) begin
            valid      <= !fill_flush;
            flush_pend <= 1'b0;
            if (fill_flush) stall_r <= 1'b0;
         end
         if (state == ST_RESP) stall_r <= 1'b0;
      end
   end

   isa_window_ram u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (beat_ok),
      .wr_addr (bus.rd_cnt_isa[RAM_AW-1:0]),
      .wr_data (bus.instruction_to_cache),
      .rd_en   (hit_rd || resp_rd),
      .rd_addr (resp_rd ? RAM_AW'(0) : off[RAM_AW-1:0]),
      .rd_data (bus.instruction)
   );

   assign bus.instr_valid   = instr_valid_r;
   assign bus.stall         = stall_r;
   assign bus.ISA_read_req  = read_req;
   assign bus.ISA_read_addr = read_addr;
   assign bus.isa_read_len  = LEN_WIDTH'(ISA_DEPTH);
endmodule

// File: tb/tb_isa_prefetch_cache.sv
// Bench for isa_prefetch_cache: directed fetch/miss/flush/reset steps, then random fetches.
// DDR side is emulated inline; instruction at PC p is always pdata(p), window hits predicted
// from a model valid/base pair using the plain offset rule.
module tb_isa_prefetch_cache;
   import isa_prefetch_cache_pkg::*;

   localparam logic [DDR_ADDR_WIDTH-1:0] TB_BASE = 28'h100_0000;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [31:0] seed;
   bit   m_valid;
   int   m_base;

   isa_prefetch_cache_if bus();

   isa_prefetch_cache #(.ISA_DDR_BASE(TB_BASE), .ADDR_SHIFT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [ISA_WIDTH-1:0] pdata(input int a);
      logic [31:0] h;
      h = (32'(a) * 32'h9E37_79B1) ^ seed;
      return h[ISA_WIDTH-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic rst_checks();
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_read_req", bus.ISA_read_req, 0);
      chk("rst_read_addr", bus.ISA_read_addr, 0);
      chk("rst_instruction", bus.instruction, 0);
   endtask

   task automatic flush_pulse();
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] pc, input bit flush_now, input int rdy_delay,
                        input bit gaps, input bit bad, input int flush_beat, input int rst_beat);
      int d;
      bit exp_hit;
      bit early;
      bit flushed;
      int waitc;
      int pass;
      int dly;
      d = int'(pc) - m_base;
      exp_hit = m_valid && !flush_now && d >= 0 && d < ISA_DEPTH;
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.pc_addr   = pc;
      bus.flush     = flush_now;
      bus.ddr_rdy   = (rdy_delay == 0);
      if (flush_now) m_valid = 1'b0;
      @(negedge clk);
      bus.flush = 1'b0;
      if (exp_hit) begin
         chk("hit_valid", bus.instr_valid, 1);
         chk("hit_data", bus.instruction, pdata(int'(pc)));
         chk("hit_no_req", bus.ISA_read_req, 0);
         chk("hit_no_stall", bus.stall, 0);
         bus.fetch_req = 1'b0;
         @(negedge clk);
         chk("hit_pulse", bus.instr_valid, 0);
         chk("hold_data", bus.instruction, pdata(int'(pc)));
         bus.ddr_rdy = 1'b1;
         return;
      end
      chk("miss_stall", bus.stall, 1);
      chk("miss_no_valid", bus.instr_valid, 0);
      dly = rdy_delay;
      for (pass = 0; pass < 3; pass++) begin
         early = 1'b0;
         repeat (dly) begin
            if (bus.ISA_read_req) early = 1'b1;
            @(negedge clk);
         end
         if (dly > 0) chk("req_gated_by_rdy", early, 0);
         bus.ddr_rdy = 1'b1;
         waitc = 0;
         while (!bus.ISA_read_req && waitc < 4) begin
            @(negedge clk);
            waitc++;
         end
         chk("req_seen", bus.ISA_read_req, 1);
         if (!bus.ISA_read_req) begin
            bus.fetch_req = 1'b0;
            return;
         end
         chk("req_addr", bus.ISA_read_addr, 64'(TB_BASE) + 64'(pc) * 8);
         chk("req_len", bus.isa_read_len, ISA_DEPTH);
         bus.ddr_rdy = 1'b0;
         early = 1'b0;
         for (int b = 0; b < ISA_DEPTH; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
               bus.rd_burst_data_valid  = 1'b0;
               bus.rd_cnt_isa           = 10'($urandom_range(0, 71));
               bus.instruction_to_cache = 30'($urandom);
               @(negedge clk);
               if (bus.instr_valid) early = 1'b1;
            end
            if (bad && b == 10) begin
               bus.rd_burst_data_valid  = 1'b1;
               bus.rd_cnt_isa           = 10'd80;
               bus.instruction_to_cache = 30'($urandom);
               @(negedge clk);
               if (bus.instr_valid) early = 1'b1;
            end
            if (b == rst_beat && pass == 0) begin
               rst_n = 1'b0;
               bus.rd_burst_data_valid = 1'b0;
               bus.fetch_req = 1'b0;
               #1;
               rst_checks();
               @(negedge clk);
               rst_n = 1'b1;
               bus.ddr_rdy = 1'b1;
               m_valid = 1'b0;
               return;
            end
            if (b == 0) chk("req_held", bus.ISA_read_req, 1);
            bus.rd_burst_data_valid  = 1'b1;
            bus.rd_cnt_isa           = 10'(b);
            bus.instruction_to_cache = pdata(int'(pc) + b);
            bus.flush                = (b == flush_beat && pass == 0);
            @(negedge clk);
            bus.flush = 1'b0;
            if (b == 0) chk("req_drop", bus.ISA_read_req, 0);
            if (bus.instr_valid) early = 1'b1;
         end
         bus.rd_burst_data_valid = 1'b0;
         flushed = (flush_beat >= 0 && pass == 0);
         chk("fill_no_early_valid", early, 0);
         chk("fill_stall_end", bus.stall, !flushed);
         @(negedge clk);
         if (flushed) begin
            chk("flush_no_valid", bus.instr_valid, 0);
            chk("flush_remiss", bus.stall, 1);
            dly = 0;
         end else begin
            chk("fill_valid", bus.instr_valid, 1);
            chk("fill_data", bus.instruction, pdata(int'(pc)));
            chk("fill_stall_clear", bus.stall, 0);
            bus.fetch_req = 1'b0;
            m_valid = 1'b1;
            m_base  = int'(pc);
            @(negedge clk);
            chk("fill_pulse", bus.instr_valid, 0);
            chk("fill_hold_data", bus.instruction, pdata(int'(pc)));
            bus.ddr_rdy = 1'b1;
            return;
         end
      end
      chk("burst_bound", pass, 2);
      bus.fetch_req = 1'b0;
      bus.ddr_rdy = 1'b1;
   endtask

   initial begin
      logic [15:0] p;
      int r;
      tests   = 0;
      fails   = 0;
      seed    = $urandom;
      m_valid = 1'b0;
      m_base  = 0;
      rst_n   = 1'b0;
      bus.fetch_req = 1'b0;
      bus.pc_addr   = '0;
      bus.flush     = 1'b0;
      bus.ddr_rdy   = 1'b1;
      bus.rd_burst_data_valid  = 1'b0;
      bus.rd_cnt_isa           = '0;
      bus.instruction_to_cache = '0;
      repeat (2) @(negedge clk);
      rst_checks();
      rst_n = 1'b1;
      @(negedge clk);
      rst_checks();

      // cold miss, then hits and window boundaries
      fetch(16'h0010, 0, 0, 0, 0, -1, -1);
      fetch(16'h0015, 0, 0, 0, 0, -1, -1);
      fetch(16'h0057, 0, 0, 0, 0, -1, -1);
      fetch(16'h0058, 0, 0, 0, 0, -1, -1);
      fetch(16'h0059, 0, 0, 0, 0, -1, -1);
      fetch(16'h000F, 0, 0, 0, 0, -1, -1);
      fetch(16'h0010, 0, 0, 0, 0, -1, -1);

      // ddr_rdy held low, gapped beats and an out-of-range beat index
      fetch(16'h0200, 0, 20, 1, 1, -1, -1);
      fetch(16'h0247, 0, 0, 0, 0, -1, -1);

      // flush during fill, held fetch re-misses
      fetch(16'h0300, 0, 0, 1, 0, 40, -1);
      fetch(16'h0305, 0, 0, 0, 0, -1, -1);

      // flush together with a would-be hit, then idle flush
      fetch(16'h0301, 1, 0, 0, 0, -1, -1);
      flush_pulse();
      fetch(16'h0302, 0, 0, 0, 0, -1, -1);

      // reset in the middle of a burst, then a clean miss
      fetch(16'h0400, 0, 0, 0, 0, -1, 30);
      fetch(16'h0400, 0, 0, 0, 0, -1, -1);
      fetch(16'h0401, 0, 0, 0, 0, -1, -1);

      // random fetches around the current window
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r == 0) flush_pulse();
         if (m_valid && $urandom_range(0, 2) != 0)
            p = 16'(m_base + int'($urandom_range(0, 85)) - 6);
         else
            p = 16'($urandom);
         fetch(p, r == 1, $urandom_range(0, 3), 1, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 71)) : -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
